// File: rtl/bbox_pkg.sv
// Shared types and constants for the digit bounding-box locator.
package bbox_pkg;

    localparam int unsigned H_ACTIVE_DEF = 1280;
    localparam int unsigned V_ACTIVE_DEF = 720;
    localparam int unsigned X_W          = 11;
    localparam int unsigned Y_W          = 10;
    localparam int unsigned RUN_W        = 4;
    localparam int unsigned ACC_W        = 12;

    localparam logic [23:0] OVERLAY_COLOR = 24'hFF0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        LATCH = 2'd2
    } state_t;

    typedef struct packed {
        logic [X_W-1:0] left;
        logic [X_W-1:0] right;
        logic [Y_W-1:0] top;
        logic [Y_W-1:0] bottom;
    } bbox_t;

endpackage

// File: rtl/bbox_run_filter.sv
// Dark-pixel detector with window gating and a per-line run counter that
// rejects short dark runs before they reach the box accumulators.
module bbox_run_filter
    import bbox_pkg::*;
#(
    parameter int unsigned THRESH  = 200,
    parameter int unsigned MIN_RUN = 3,
    parameter int unsigned WIN_L   = 0,
    parameter int unsigned WIN_R   = 1279,
    parameter int unsigned WIN_T   = 0,
    parameter int unsigned WIN_B   = 719
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           de,
    input  logic [7:0]     blue,
    input  logic [X_W-1:0] x,
    input  logic [Y_W-1:0] y,
    output logic           qualify_c,
    output logic           run_start_c
);

    logic [RUN_W-1:0] run_cnt;
    logic [RUN_W-1:0] run_base;
    logic [RUN_W-1:0] run_next;
    logic             dark;
    logic             in_win;

    always_comb begin
        dark     = blue < 8'(THRESH);
        // Biased lower-bound compares stay meaningful when the window starts at 0.
        in_win   = ({1'b1, x} >= {1'b1, X_W'(WIN_L)}) && (x <= X_W'(WIN_R)) &&
                   ({1'b1, y} >= {1'b1, Y_W'(WIN_T)}) && (y <= Y_W'(WIN_B));
        run_base = (x == '0) ? '0 : run_cnt;
        run_next = '0;
        if (dark && in_win) begin
            run_next = (run_base == '1) ? run_base : run_base + RUN_W'(1);
        end
        qualify_c   = de && dark && in_win && (run_next >= RUN_W'(MIN_RUN));
        run_start_c = qualify_c && (run_base < RUN_W'(MIN_RUN));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_cnt <= '0;
        end else if (de) begin
            run_cnt <= run_next;
        end
    end

endmodule

// File: rtl/digit_bbox_locator.sv
// Tracks the bounding box of dark glyph pixels per frame and publishes it at frame end.
// Optional BBOX_OVERLAY_EN adds RGB_Data_Out with the published box drawn in red.
module digit_bbox_locator
    import bbox_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned THRESH   = 200,
    parameter int unsigned MIN_RUN  = 3,
    parameter int unsigned MIN_SIZE = 8,
    parameter int unsigned WIN_L    = 0,
    parameter int unsigned WIN_R    = 1279,
    parameter int unsigned WIN_T    = 0,
    parameter int unsigned WIN_B    = 719
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           RGB_de_Src,
    input  logic [23:0]    RGB_Data_Src,
    input  logic [X_W-1:0] RGB_x_Src,
    input  logic [Y_W-1:0] RGB_y_Src,
    output logic [X_W-1:0] left,
    output logic [X_W-1:0] right,
    output logic [Y_W-1:0] top,
    output logic [Y_W-1:0] bottom,
    output logic           box_valid,
    output logic           box_update
`ifdef BBOX_OVERLAY_EN
    ,
    output logic [23:0]    RGB_Data_Out
`endif
);

    state_t         state;
    state_t         state_next;
    logic           qualify;
    logic           run_start;
    logic           origin;
    logic           last_px;
    logic           clr_acc;
    logic           acc_en;
    logic           publish;
    logic           accept;

    bbox_t          acc;
    bbox_t          acc_next;
    logic           hit;
    logic           hit_next;
    logic [X_W-1:0] cand_x;
    logic [ACC_W-1:0] width;
    logic [ACC_W-1:0] height;

    bbox_run_filter #(
        .THRESH  (THRESH),
        .MIN_RUN (MIN_RUN),
        .WIN_L   (WIN_L),
        .WIN_R   (WIN_R),
        .WIN_T   (WIN_T),
        .WIN_B   (WIN_B)
    ) u_run_filter (
        .clk         (clk),
        .rst         (rst),
        .de          (RGB_de_Src),
        .blue        (RGB_Data_Src[7:0]),
        .x           (RGB_x_Src),
        .y           (RGB_y_Src),
        .qualify_c   (qualify),
        .run_start_c (run_start)
    );

    assign origin  = RGB_de_Src && (RGB_x_Src == '0) && (RGB_y_Src == '0);
    assign last_px = RGB_de_Src && (RGB_x_Src == X_W'(H_ACTIVE - 1)) &&
                     (RGB_y_Src == Y_W'(V_ACTIVE - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Publishing is decided on the last pixel so outputs land on the next edge.
    always_comb begin
        state_next = state;
        clr_acc    = 1'b0;
        acc_en     = 1'b0;
        publish    = 1'b0;
        case (state)
            IDLE: begin
                if (origin) begin
                    clr_acc    = 1'b1;
                    acc_en     = 1'b1;
                    state_next = SCAN;
                end
            end
            SCAN: begin
                if (RGB_de_Src) begin
                    acc_en = 1'b1;
                    if (origin) begin
                        clr_acc = 1'b1;
                    end else if (last_px) begin
                        publish    = 1'b1;
                        state_next = LATCH;
                    end
                end
            end
            LATCH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        acc_next = acc;
        hit_next = hit;
        if (clr_acc) begin
            acc_next.left   = '1;
            acc_next.right  = '0;
            acc_next.top    = '1;
            acc_next.bottom = '0;
            hit_next        = 1'b0;
        end
        cand_x = run_start ? (RGB_x_Src - X_W'(MIN_RUN - 1)) : RGB_x_Src;
        if (qualify) begin
            if (cand_x < acc_next.left)      acc_next.left   = cand_x;
            if (RGB_x_Src > acc_next.right)  acc_next.right  = RGB_x_Src;
            if (RGB_y_Src < acc_next.top)    acc_next.top    = RGB_y_Src;
            if (RGB_y_Src > acc_next.bottom) acc_next.bottom = RGB_y_Src;
            hit_next = 1'b1;
        end
        width  = {1'b0, acc_next.right} - {1'b0, acc_next.left} + ACC_W'(1);
        height = {2'b00, acc_next.bottom} - {2'b00, acc_next.top} + ACC_W'(1);
        accept = hit_next && (width >= ACC_W'(MIN_SIZE)) && (height >= ACC_W'(MIN_SIZE));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc.left   <= '1;
            acc.right  <= '0;
            acc.top    <= '1;
            acc.bottom <= '0;
            hit        <= 1'b0;
        end else if (acc_en) begin
            acc <= acc_next;
            hit <= hit_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            left       <= '0;
            right      <= '0;
            top        <= '0;
            bottom     <= '0;
            box_valid  <= 1'b0;
            box_update <= 1'b0;
        end else begin
            box_update <= publish;
            if (publish) begin
                box_valid <= accept;
                if (accept) begin
                    left   <= acc_next.left;
                    right  <= acc_next.right;
                    top    <= acc_next.top;
                    bottom <= acc_next.bottom;
                end
            end
        end
    end

`ifdef BBOX_OVERLAY_EN
    logic on_h;
    logic on_v;

    always_comb begin
        on_h = ((RGB_y_Src == top) || (RGB_y_Src == bottom)) &&
               (RGB_x_Src >= left) && (RGB_x_Src <= right);
        on_v = ((RGB_x_Src == left) || (RGB_x_Src == right)) &&
               (RGB_y_Src >= top) && (RGB_y_Src <= bottom);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            RGB_Data_Out <= '0;
        end else begin
            RGB_Data_Out <= (box_valid && (on_h || on_v)) ? OVERLAY_COLOR : RGB_Data_Src;
        end
    end
`else
    logic unused_data_hi;
    assign unused_data_hi = ^RGB_Data_Src[23:8];
`endif

endmodule

// File: tb/tb_digit_bbox_locator.sv
// Scoreboard bench for digit_bbox_locator: sparse frames carry only the pixels
// around each glyph plus the frame-start and frame-end pixels.
module tb_digit_bbox_locator;

    logic        clk = 1'b0;
    logic        rst;
    logic        de;
    logic [23:0] data;
    logic [10:0] px_x;
    logic [9:0]  px_y;
    logic [10:0] left;
    logic [10:0] right;
    logic [9:0]  top;
    logic [9:0]  bottom;
    logic        box_valid;
    logic        box_update;
`ifdef BBOX_OVERLAY_EN
    logic [23:0] data_out;
`endif

    typedef struct {
        int x0;
        int x1;
        int y0;
        int y1;
    } rect_t;

    int           checks  = 0;
    int           errors  = 0;
    int           updates = 0;
    int           pix_n   = 0;
    logic [42:0]  exp_q[$];
    rect_t        rects[$];

    always #5 clk = ~clk;

    digit_bbox_locator dut (
        .clk          (clk),
        .rst          (rst),
        .RGB_de_Src   (de),
        .RGB_Data_Src (data),
        .RGB_x_Src    (px_x),
        .RGB_y_Src    (px_y),
        .left         (left),
        .right        (right),
        .top          (top),
        .bottom       (bottom),
        .box_valid    (box_valid),
        .box_update   (box_update)
`ifdef BBOX_OVERLAY_EN
        ,
        .RGB_Data_Out (data_out)
`endif
    );

    function automatic logic [42:0] box(input int l, input int r, input int t, input int b,
                                        input bit v);
        return {11'(l), 11'(r), 10'(t), 10'(b), v};
    endfunction

    function automatic bit is_dark(input int x, input int y);
        foreach (rects[i]) begin
            if (x >= rects[i].x0 && x <= rects[i].x1 && y >= rects[i].y0 && y <= rects[i].y1)
                return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic chk(input string name, input logic [42:0] act, input logic [42:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every published update must match the oldest expectation.
    always @(negedge clk) begin
        if (box_update === 1'b1) begin
            updates++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_update actual=%h required=none at %0t",
                         {left, right, top, bottom, box_valid}, $time);
            end else begin
                chk("box_update", {left, right, top, bottom, box_valid}, exp_q.pop_front());
            end
        end
    end

    // One valid pixel; a blanking cycle with misleading (0,0) dark data is mixed in regularly.
    task automatic pix(input int x, input int y, input bit dark);
        @(posedge clk);
        #1;
        de   = 1'b1;
        px_x = 11'(x);
        px_y = 10'(y);
        data = dark ? 24'hFFFF00 : 24'hFFFFFF;
        pix_n++;
        if (pix_n % 13 == 0) begin
            @(posedge clk);
            #1;
            de   = 1'b0;
            px_x = '0;
            px_y = '0;
            data = '0;
        end
    endtask

    task automatic idle(input int n);
        @(posedge clk);
        #1;
        de = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame(input int xa, input int xb, input int ya, input int yb, input bit complete);
        pix(0, 0, 1'b0);
        for (int y = ya; y <= yb; y++) begin
            for (int x = xa; x <= xb; x++) begin
                pix(x, y, is_dark(x, y));
            end
        end
        if (complete) pix(1279, 719, 1'b0);
        idle(4);
    endtask

    initial begin
        rst  = 1'b1;
        de   = 1'b0;
        data = '0;
        px_x = '0;
        px_y = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_box", {left, right, top, bottom, box_valid}, box(0, 0, 0, 0, 0));
        chk("reset_update", 43'(box_update), 43'(0));

        // 20x30 black rectangle
        rects.push_back('{600, 619, 300, 329});
        exp_q.push_back(box(600, 619, 300, 329, 1));
        frame(580, 640, 280, 350, 1'b1);

        // Two-pixel specks must not extend the box
        rects.push_back('{590, 591, 290, 290});
        rects.push_back('{630, 631, 340, 340});
        rects.push_back('{585, 586, 345, 345});
        exp_q.push_back(box(600, 619, 300, 329, 1));
        frame(580, 640, 280, 350, 1'b1);

        // All-white frame: coordinates hold, valid drops
        rects.delete();
        exp_q.push_back(box(600, 619, 300, 329, 0));
        frame(580, 640, 280, 350, 1'b1);
        @(negedge clk);
        chk("hold_after_white", {left, right, top, bottom, box_valid}, box(600, 619, 300, 329, 0));

        // 5x5 square is below minimum size
        rects.push_back('{610, 614, 310, 314});
        exp_q.push_back(box(600, 619, 300, 329, 0));
        frame(580, 640, 280, 350, 1'b1);

        // Reset in the middle of a frame
        rects.delete();
        rects.push_back('{600, 619, 300, 329});
        pix(0, 0, 1'b0);
        for (int y = 280; y <= 350; y++) begin
            for (int x = 580; x <= 640; x++) pix(x, y, is_dark(x, y));
        end
        pix(5, 400, 1'b0);
        @(posedge clk);
        #1;
        de  = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midframe_reset_box", {left, right, top, bottom, box_valid}, box(0, 0, 0, 0, 0));
        chk("midframe_reset_update", 43'(box_update), 43'(0));
        exp_q.push_back(box(600, 619, 300, 329, 1));
        frame(580, 640, 280, 350, 1'b1);

        // Truncated frame followed by a complete frame with a different glyph
        rects.delete();
        rects.push_back('{100, 129, 50, 69});
        frame(95, 135, 45, 75, 1'b0);
        rects.delete();
        rects.push_back('{900, 909, 600, 611});
        exp_q.push_back(box(900, 909, 600, 611, 1));
        frame(895, 915, 595, 615, 1'b1);

        idle(6);
        @(negedge clk);
        chk("queue_drained", 43'(exp_q.size()), 43'(0));
        chk("update_count", 43'(updates), 43'(6));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
